// File: rtl/free_list_pkg.sv
// -----------------------------------------------------------------------------
// free_list_pkg
// Shared constants for the rename-stage physical register free list.
//   PRF_IDX    : physical register index width
//   ARF_COUNT  : architectural registers (PRF 0..ARF_COUNT-1 start mapped)
//   ID_WIDTH   : number of stale-index return lanes from the RRF
//   FL_DEPTH   : free list entries (power of two)
//   FL_PTR_W   : head/tail width, index bits plus one wrap bit
//   LANE_CNT_W : width able to hold a popcount of ID_WIDTH lanes
// -----------------------------------------------------------------------------
package free_list_pkg;
  localparam int PRF_IDX    = 6;
  localparam int ARF_COUNT  = 32;
  localparam int ID_WIDTH   = 2;
  localparam int FL_DEPTH   = (2 ** PRF_IDX) - ARF_COUNT;
  localparam int FL_PTR_W   = $clog2(FL_DEPTH) + 1;
  localparam int LANE_CNT_W = $clog2(ID_WIDTH + 1);
endpackage

// File: rtl/free_list_chk.sv
// -----------------------------------------------------------------------------
// free_list_chk
// Protocol checks on the RRF return path of the free list.
//   clk, rst : clock and synchronous reset (checks disabled during reset)
//   i_count  : current occupancy (tail - head)
//   i_total  : number of lanes enqueuing this cycle
//   i_valid  : RRF lane valids
//   i_stale  : RRF stale indices, lane-packed
// -----------------------------------------------------------------------------
module free_list_chk
  import free_list_pkg::*;
(
  input logic                        clk,
  input logic                        rst,
  input logic [FL_PTR_W-1:0]         i_count,
  input logic [LANE_CNT_W-1:0]       i_total,
  input logic [ID_WIDTH-1:0]         i_valid,
  input logic [ID_WIDTH*PRF_IDX-1:0] i_stale
);

  // PRF accounting guarantees returns never exceed the free capacity
  a_no_overflow: assert property (@(posedge clk) disable iff (rst)
    (int'(i_count) + int'(i_total)) <= FL_DEPTH);

  for (genvar l = 0; l < ID_WIDTH; l++) begin : g_lane
    // x0 is never renamed, so it can never come back as a stale index
    a_no_zero: assert property (@(posedge clk) disable iff (rst)
      !(i_valid[l] && (i_stale[l*PRF_IDX +: PRF_IDX] == {PRF_IDX{1'b0}})));
  end

endmodule

// File: rtl/free_list_lane_compact.sv
// -----------------------------------------------------------------------------
// fl_lane_compact
// Prefix popcount over the RRF lane valids. Each valid lane lands at
// tail + (number of valid lanes below it), so holes are squeezed out.
//   i_valid  : per-lane valid from the RRF
//   o_offset : per-lane slot offset from tail (LANE_CNT_W bits per lane)
//   o_total  : popcount of i_valid (tail advance)
// -----------------------------------------------------------------------------
module fl_lane_compact
  import free_list_pkg::*;
(
  input  logic [ID_WIDTH-1:0]            i_valid,
  output logic [ID_WIDTH*LANE_CNT_W-1:0] o_offset,
  output logic [LANE_CNT_W-1:0]          o_total
);

  logic [LANE_CNT_W-1:0] w_acc;

  // Running count of valid lanes strictly below each lane
  always_comb begin
    w_acc    = {LANE_CNT_W{1'b0}};
    o_offset = {(ID_WIDTH*LANE_CNT_W){1'b0}};
    for (int i = 0; i < ID_WIDTH; i++) begin
      o_offset[i*LANE_CNT_W +: LANE_CNT_W] = w_acc;
      w_acc = w_acc + LANE_CNT_W'(i_valid[i]);
    end
    o_total = w_acc;
  end

endmodule

// File: rtl/free_list.sv
// -----------------------------------------------------------------------------
// free_list
// Physical register free list: circular FIFO of FL_DEPTH PRF indices.
// Hands one free index per cycle to ID and accepts up to ID_WIDTH stale
// indices per cycle from the RRF. Backend flush makes the list full again.
//   clk, rst         : clock, synchronous active-high reset
//   backend_flush    : mispredict recovery, list returns to full
//   i_id_valid       : ID dequeue request
//   o_id_ready       : list not empty
//   o_id_free_idx    : index at head (combinational; meaningless when empty)
//   i_rrf_valid      : per-lane RRF return valid
//   i_rrf_stale_idx  : per-lane stale index, lane l at [l*PRF_IDX +: PRF_IDX]
// -----------------------------------------------------------------------------
module free_list
  import free_list_pkg::*;
(
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        backend_flush,
  input  logic                        i_id_valid,
  output logic                        o_id_ready,
  output logic [PRF_IDX-1:0]          o_id_free_idx,
  input  logic [ID_WIDTH-1:0]         i_rrf_valid,
  input  logic [ID_WIDTH*PRF_IDX-1:0] i_rrf_stale_idx
);

  localparam int IDX_W = FL_PTR_W - 1;

  logic [FL_PTR_W-1:0]            r_head;
  logic [FL_PTR_W-1:0]            r_tail;
  logic [FL_PTR_W-1:0]            w_head_n;
  logic [FL_PTR_W-1:0]            w_tail_n;
  logic [FL_PTR_W-1:0]            w_count;
  logic                           w_empty;
  logic                           w_deq;
  logic [ID_WIDTH*LANE_CNT_W-1:0] w_offset;
  logic [LANE_CNT_W-1:0]          w_total;
  logic [IDX_W-1:0]               w_waddr [ID_WIDTH];
  logic [FL_DEPTH-1:0]            w_we;
  logic [PRF_IDX-1:0]             w_wdata [FL_DEPTH];
  logic [PRF_IDX-1:0]             w_slot  [FL_DEPTH];

  fl_lane_compact u_compact (
    .i_valid  (i_rrf_valid),
    .o_offset (w_offset),
    .o_total  (w_total)
  );

  free_list_chk u_chk (
    .clk     (clk),
    .rst     (rst),
    .i_count (w_count),
    .i_total (w_total),
    .i_valid (i_rrf_valid),
    .i_stale (i_rrf_stale_idx)
  );

  assign w_empty       = (r_head == r_tail);
  assign w_count       = r_tail - r_head;
  // A flush owns the head this cycle, so an ID request is dropped
  assign w_deq         = i_id_valid & ~w_empty & ~backend_flush;
  assign w_tail_n      = r_tail + FL_PTR_W'(w_total);
  assign o_id_ready    = ~w_empty;
  assign o_id_free_idx = w_slot[r_head[IDX_W-1:0]];

  // Head update: on flush, sit one full lap behind the post-enqueue tail
  always_comb begin
    w_head_n = r_head;
    if (backend_flush) begin
      w_head_n = {~w_tail_n[FL_PTR_W-1], w_tail_n[IDX_W-1:0]};
    end else if (w_deq) begin
      w_head_n = r_head + FL_PTR_W'(1);
    end else begin
      w_head_n = r_head;
    end
  end

  // Physical slot for each lane; index bits wrap naturally modulo FL_DEPTH
  always_comb begin
    for (int l = 0; l < ID_WIDTH; l++) begin
      w_waddr[l] = r_tail[IDX_W-1:0] + IDX_W'(w_offset[l*LANE_CNT_W +: LANE_CNT_W]);
    end
  end

  // Per-slot write enable and data from the compacted lanes
  always_comb begin
    for (int g = 0; g < FL_DEPTH; g++) begin
      w_we[g]    = 1'b0;
      w_wdata[g] = {PRF_IDX{1'b0}};
      for (int l = 0; l < ID_WIDTH; l++) begin
        if (i_rrf_valid[l] && (w_waddr[l] == IDX_W'(g))) begin
          w_we[g]    = 1'b1;
          w_wdata[g] = i_rrf_stale_idx[l*PRF_IDX +: PRF_IDX];
        end else begin
          w_we[g]    = w_we[g];
        end
      end
    end
  end

  // Pointer registers; reset leaves the list full (wrap bits differ)
  always_ff @(posedge clk) begin
    if (rst) begin
      r_head <= {FL_PTR_W{1'b0}};
      r_tail <= {1'b1, {IDX_W{1'b0}}};
    end else begin
      r_head <= w_head_n;
      r_tail <= w_tail_n;
    end
  end

  for (genvar g = 0; g < FL_DEPTH; g++) begin : g_entry
    logic [PRF_IDX-1:0] r_slot;

    // Storage slot; reset preloads the non-architectural PRF indices
    always_ff @(posedge clk) begin
      if (rst) begin
        r_slot <= PRF_IDX'(ARF_COUNT + g);
      end else if (w_we[g]) begin
        r_slot <= w_wdata[g];
      end else begin
        r_slot <= r_slot;
      end
    end

    assign w_slot[g] = r_slot;
  end

endmodule

// File: doc/free_list.md
Name: free_list

Overview:
- Physical-register free list for the rename stage.
- Serves the fl side of id_fl_itf: supplies one free PRF index per cycle to ID.
- Serves the fl side of rrf_fl_itf: accepts up to ID_WIDTH stale PRF indices per cycle returned by the RRF at commit.
- Circular FIFO of depth PRF_COUNT-ARF_COUNT. Restores to full on backend flush.

Parameters:
- PRF_IDX, cpu_params::PRF_IDX (6): physical register index width.
- ARF_COUNT, 32: architectural registers; PRF 0..ARF_COUNT-1 are never in the list at reset.
- DEPTH, 2**PRF_IDX-ARF_COUNT (32): FIFO entries; power of two required.
- ID_WIDTH, cpu_params::ID_WIDTH (2): enqueue lanes from RRF.

Ports:
- clk, in, 1: clock.
- rst, in, 1: synchronous active-high reset.
- backend_flush, in, 1: mispredict recovery; list returns to full.
- from_id, id_fl_itf.fl, modport: valid (dequeue request) in; ready out; free_idx[PRF_IDX] out.
- from_rrf, rrf_fl_itf.fl, modport: valid[ID_WIDTH] in; stale_idx[ID_WIDTH][PRF_IDX] in.

Behaviour:
- Storage: mem[DEPTH] of PRF_IDX bits. head and tail are log2(DEPTH)+1 bits; the MSB is the wrap bit.
- Empty when head == tail. Full when the index bits are equal and the wrap bits differ.
- Reset (rst=1 at posedge):
  - mem[i] <= ARF_COUNT+i.
  - head <= 0; tail <= {1'b1, 0}, so the list is full.
  - Outputs after reset: ready=1, free_idx=ARF_COUNT (32).
  - Reset wins over flush and all traffic in the same cycle.
- Dequeue:
  - ready = !empty; free_idx = mem[head[idx]], combinational, zero latency.
  - On valid && ready: head <= head+1 at the edge; next free_idx visible the following cycle.
  - valid while empty: no state change, ready stays 0.
  - free_idx is don't-care when empty; the bench must not check it.
- Enqueue:
  - Lane i with valid[i] writes stale_idx[i] to mem[(tail + count of valid lanes j<i) mod DEPTH]. Lanes are packed in lane order, and holes are skipped.
  - tail <= tail + popcount(valid), with natural wrap.
  - Written entries are dequeue-visible the next cycle. No same-cycle bypass: enqueue into an empty list keeps ready=0 that cycle.
- Simultaneous enqueue and dequeue: both applied. Count changes by popcount(valid) - deq.
- Overflow: an enqueue with count + popcount > DEPTH is a protocol error, impossible by PRF accounting. Simulation assertion fires; RTL behaviour is undefined.
- stale_idx == 0 with valid is illegal (x0 is never renamed). Simulation assertion fires.
- Flush (backend_flush=1, rst=0):
  - RRF enqueues in that cycle are applied first, giving tail_n.
  - head <= {~tail_n[MSB], tail_n[idx bits]}, so the list becomes full with exactly the DEPTH entries physically present.
  - ID dequeue that cycle is ignored; the head is not advanced by it.
  - ready=1 from the next cycle.
  - Correctness relies on the architectural set being the RRF's DEPTH-complement.
- Wrap-around: pointers wrap modulo 2*DEPTH. No special casing beyond the index/wrap-bit split.
- Only the head/tail registers and mem are sequential; there is no FSM.

Decomposition:
- cpu_params: PRF_IDX, ARF_COUNT, ID_WIDTH, and a derived FL_DEPTH constant.
- The enqueue-offset prefix-popcount is natural as a sub-module, fl_lane_compact. It takes valid[ID_WIDTH] and returns offset[ID_WIDTH] and total.
- Everything else lives in free_list.

Test Plan:
- Reset then hold valid=1 for 33 cycles. free_idx is 32,33,...,63 on successive cycles, and ready drops to 0 after the 32nd dequeue. No 33rd dequeue occurs.
- From empty, RRF valid={1,1}, stale={5,9}. ready=0 that cycle and 1 the next. Dequeues yield 5 then 9, then ready=0.
- Lane packing: RRF valid={0,1} with stale[1]=12, then valid={1,0} with stale[0]=7. Dequeues yield 12 then 7.
- Simultaneous: with 4 entries present, dequeue plus enqueue 2 each cycle for 40 cycles. Pointers wrap, the count grows by 1 per cycle, capped at full (the bench stops enqueuing at full), and FIFO order is preserved.
- Flush: reset, dequeue 10 (32..41), enqueue 3, dequeue 2, assert backend_flush with a 1-lane enqueue. Next cycle the list is full (32 entries) and the head points just past the last enqueued slot. The sequence restarts at the oldest surviving entry; verify the order against a model.
- rst asserted mid-traffic together with flush and enqueue. The next cycle matches the post-reset state: free_idx=32, ready=1, full.
